// File: rtl/fifo_protocol_monitor.sv
// Passive monitor for a single-clock FIFO. It keeps a shadow occupancy count and a shadow copy of
// the stored data, and reports protocol, flag and data errors as sticky bits and a counter.
module fifo_protocol_monitor #(
  parameter int unsigned DATA        = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned RD_LAT      = 0,
  parameter bit          CHECK_FLAGS = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       winc,
  input  logic [DATA-1:0]            wdata,
  input  logic                       wfull,
  input  logic                       rinc,
  input  logic [DATA-1:0]            rdata,
  input  logic                       rempty,
  input  logic                       clr_err,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err_ovf,
  output logic                       err_udf,
  output logic                       err_full,
  output logic                       err_empty,
  output logic                       err_data,
  output logic [CNT_W-1:0]           err_count,
  output logic [2:0]                 first_code,
  output logic                       irq
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  // Event / sticky bit positions; the first-error code of bit i is i+1.
  localparam int unsigned EvOvf   = 0;
  localparam int unsigned EvUdf   = 1;
  localparam int unsigned EvFull  = 2;
  localparam int unsigned EvEmpty = 3;
  localparam int unsigned EvData  = 4;

  logic [DATA-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [OccW-1:0] occ_q, occ_d;

  logic            wr_acc;
  logic            rd_acc;
  logic [DATA-1:0] exp_rd;
  logic            data_evt;

  logic [4:0]       evt;
  logic [4:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       first_q, first_d;
  logic             irq_q;

  assign wr_acc = winc & ~wfull;
  assign rd_acc = rinc & ~rempty;
  assign exp_rd = mem_q[rptr_q];

  // Shadow data is not reset; the pointers and occupancy alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (wr_acc) begin
      wptr_d = (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (rd_acc) begin
      rptr_d = (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign data_evt = rd_acc && (rdata != exp_rd);
    end else begin : g_lat1
      logic [DATA-1:0] exp_q;
      logic            vld_q;

      always_ff @(posedge clk) begin
        if (rd_acc) begin
          exp_q <= exp_rd;
        end
      end

      always_ff @(posedge clk) begin
        if (!rstn) begin
          vld_q <= 1'b0;
        end else begin
          vld_q <= rd_acc;
        end
      end

      assign data_evt = vld_q && (rdata != exp_q);
    end
  endgenerate

  always_comb begin
    evt          = '0;
    evt[EvOvf]   = winc & wfull;
    evt[EvUdf]   = rinc & rempty;
    evt[EvFull]  = CHECK_FLAGS && (wfull != (occ_q == OccW'(DEPTH)));
    evt[EvEmpty] = CHECK_FLAGS && (rempty != (occ_q == '0));
    evt[EvData]  = data_evt;
  end

  // A clear wipes the old state first, so an event in the same cycle is still recorded.
  always_comb begin
    sticky_d = (clr_err ? '0 : sticky_q) | evt;
    cnt_d    = clr_err ? '0 : cnt_q;
    first_d  = clr_err ? '0 : first_q;
    if ((|evt) && (cnt_d != '1)) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
    if (first_d == '0) begin
      for (int i = 4; i >= 0; i--) begin
        if (evt[i]) begin
          first_d = 3'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sticky_q <= '0;
      cnt_q    <= '0;
      first_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      irq_q    <= |sticky_d;
    end
  end

  assign occupancy  = occ_q;
  assign err_ovf    = sticky_q[EvOvf];
  assign err_udf    = sticky_q[EvUdf];
  assign err_full   = sticky_q[EvFull];
  assign err_empty  = sticky_q[EvEmpty];
  assign err_data   = sticky_q[EvData];
  assign err_count  = cnt_q;
  assign first_code = first_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_fifo_protocol_monitor.sv
// Directed, table-driven bench for fifo_protocol_monitor: one DEPTH=4 FWFT instance carries the
// full table, with RD_LAT=1 and CHECK_FLAGS=0 instances checked at selected rows.
module tb_fifo_protocol_monitor;

  logic       clk;
  logic       rstn;
  logic       winc;
  logic [7:0] wdata;
  logic       wfull;
  logic       rinc;
  logic [7:0] rdata;
  logic       rempty;
  logic       clr_err;

  logic [2:0] occ_a, occ_b, occ_c;
  logic       ovf_a, udf_a, full_a, empty_a, data_a;
  logic       ovf_b, udf_b, full_b, empty_b, data_b;
  logic       ovf_c, udf_c, full_c, empty_c, data_c;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [2:0] first_a, first_b, first_c;
  logic       irq_a, irq_b, irq_c;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_protocol_monitor #(.DATA(8), .DEPTH(4), .RD_LAT(0), .CHECK_FLAGS(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rstn(rstn), .winc(winc), .wdata(wdata), .wfull(wfull), .rinc(rinc),
    .rdata(rdata), .rempty(rempty), .clr_err(clr_err), .occupancy(occ_a), .err_ovf(ovf_a),
    .err_udf(udf_a), .err_full(full_a), .err_empty(empty_a), .err_data(data_a),
    .err_count(cnt_a), .first_code(first_a), .irq(irq_a)
  );

  fifo_protocol_monitor #(.DATA(8), .DEPTH(4), .RD_LAT(1), .CHECK_FLAGS(1'b1), .CNT_W(8)) u_b (
    .clk(clk), .rstn(rstn), .winc(winc), .wdata(wdata), .wfull(wfull), .rinc(rinc),
    .rdata(rdata), .rempty(rempty), .clr_err(clr_err), .occupancy(occ_b), .err_ovf(ovf_b),
    .err_udf(udf_b), .err_full(full_b), .err_empty(empty_b), .err_data(data_b),
    .err_count(cnt_b), .first_code(first_b), .irq(irq_b)
  );

  fifo_protocol_monitor #(.DATA(8), .DEPTH(4), .RD_LAT(0), .CHECK_FLAGS(1'b0), .CNT_W(8)) u_c (
    .clk(clk), .rstn(rstn), .winc(winc), .wdata(wdata), .wfull(wfull), .rinc(rinc),
    .rdata(rdata), .rempty(rempty), .clr_err(clr_err), .occupancy(occ_c), .err_ovf(ovf_c),
    .err_udf(udf_c), .err_full(full_c), .err_empty(empty_c), .err_data(data_c),
    .err_count(cnt_c), .first_code(first_c), .irq(irq_c)
  );

  // err is {ovf, udf, full, empty, data}; e1/e2 are RD_LAT=1 err_data and CHECK_FLAGS=0
  // err_empty expectations, -1 where that instance is not checked.
  typedef struct {
    logic       rst;
    logic       w;
    logic [7:0] wd;
    logic       wf;
    logic       r;
    logic [7:0] rd;
    logic       re;
    logic       clr;
    int         occ;
    logic [4:0] err;
    int         cnt;
    int         first;
    int         e1;
    int         e2;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic rst, input logic w, input logic [7:0] wd, input logic wf,
                   input logic r, input logic [7:0] rd, input logic re, input logic clr,
                   input int occ, input logic [4:0] err, input int cnt, input int first,
                   input int e1, input int e2);
    vec_t t;
    t.rst = rst; t.w = w; t.wd = wd; t.wf = wf; t.r = r; t.rd = rd; t.re = re; t.clr = clr;
    t.occ = occ; t.err = err; t.cnt = cnt; t.first = first; t.e1 = e1; t.e2 = e2;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic w, input logic [7:0] wd, input logic wf,
                       input logic r, input logic [7:0] rd, input logic re, input logic clr);
    rstn = ~rst; winc = w; wdata = wd; wfull = wf; rinc = r; rdata = rd; rempty = re;
    clr_err = clr;
  endtask

  task automatic chk_main(input string tag, input int occ, input logic [4:0] err, input int cnt,
                          input int first);
    chk({tag, " occupancy"}, int'(occ_a), occ);
    chk({tag, " err_bits"}, int'({ovf_a, udf_a, full_a, empty_a, data_a}), int'(err));
    chk({tag, " err_count"}, int'(cnt_a), cnt);
    chk({tag, " first_code"}, int'(first_a), first);
    chk({tag, " irq"}, int'(irq_a), int'(|err));
  endtask

  initial begin
    // Fill to full, then overflow.
    v(0, 1, 8'h11, 0, 0, 8'h00, 1, 0, 1, 5'b00000, 0, 0, -1, -1);
    v(0, 1, 8'h22, 0, 0, 8'h00, 0, 0, 2, 5'b00000, 0, 0, -1, -1);
    v(0, 1, 8'h33, 0, 0, 8'h00, 0, 0, 3, 5'b00000, 0, 0, -1, -1);
    v(0, 1, 8'h44, 0, 0, 8'h00, 0, 0, 4, 5'b00000, 0, 0, -1, -1);
    v(0, 1, 8'h55, 1, 0, 8'h00, 0, 0, 4, 5'b10000, 1, 1, -1, -1);
    // Drain with matching data, then underflow.
    v(0, 0, 8'h00, 1, 1, 8'h11, 0, 0, 3, 5'b10000, 1, 1, -1, -1);
    v(0, 0, 8'h00, 0, 1, 8'h22, 0, 0, 2, 5'b10000, 1, 1, -1, -1);
    v(0, 0, 8'h00, 0, 1, 8'h33, 0, 0, 1, 5'b10000, 1, 1, -1, -1);
    v(0, 0, 8'h00, 0, 1, 8'h44, 0, 0, 0, 5'b10000, 1, 1, -1, -1);
    v(0, 0, 8'h00, 0, 1, 8'h44, 1, 0, 0, 5'b11000, 2, 1, -1, -1);
    // Clear, then a corrupted read.
    v(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 5'b00000, 0, 0, -1, -1);
    v(0, 1, 8'hA5, 0, 0, 8'h00, 1, 0, 1, 5'b00000, 0, 0,  0, -1);
    v(0, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 0, 5'b00001, 1, 5,  0, -1);
    v(0, 0, 8'h00, 0, 0, 8'h5A, 1, 0, 0, 5'b00001, 1, 5,  1, -1);
    // Clear, then rempty wrongly low for three cycles.
    v(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 5'b00000, 0, 0, -1, -1);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 5'b00010, 1, 4, -1,  0);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 5'b00010, 2, 4, -1,  0);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 5'b00010, 3, 4, -1,  0);
    // Clear while priming to occupancy 2, then ten write/read pairs that wrap the pointers.
    v(0, 1, 8'hE0, 0, 0, 8'h00, 1, 1, 1, 5'b00000, 0, 0, -1, -1);
    v(0, 1, 8'hE1, 0, 0, 8'h00, 0, 0, 2, 5'b00000, 0, 0, -1, -1);
    for (int i = 0; i < 10; i++) begin
      v(0, 1, 8'(i), 0, 1, (i == 0) ? 8'hE0 : (i == 1) ? 8'hE1 : 8'(i - 2), 0, 0,
        2, 5'b00000, 0, 0, -1, -1);
    end
    // Fill, then overflow coincident with a clear.
    v(0, 1, 8'h0A, 0, 0, 8'h00, 0, 0, 3, 5'b00000, 0, 0, -1, -1);
    v(0, 1, 8'h0B, 0, 0, 8'h00, 0, 0, 4, 5'b00000, 0, 0, -1, -1);
    v(0, 1, 8'hCC, 1, 0, 8'h00, 0, 1, 4, 5'b10000, 1, 1, -1, -1);
    // Bad read (oldest entry is 0x08), mid-run reset, then underflow.
    v(0, 0, 8'h00, 1, 1, 8'hFF, 0, 0, 3, 5'b10001, 2, 1, -1, -1);
    v(1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 5'b00000, 0, 0,  0,  0);
    v(0, 0, 8'h00, 0, 1, 8'h00, 1, 0, 0, 5'b01000, 1, 2, -1, -1);

    drive(1, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_main("reset", 0, 5'b00000, 0, 0);
    chk("reset rdlat1 err_data", int'(data_b), 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].w, tbl[i].wd, tbl[i].wf, tbl[i].r, tbl[i].rd, tbl[i].re,
            tbl[i].clr);
      @(posedge clk);
      #1;
      chk_main($sformatf("row%0d", i), tbl[i].occ, tbl[i].err, tbl[i].cnt, tbl[i].first);
      if (tbl[i].e1 >= 0) chk($sformatf("row%0d rdlat1 err_data", i), int'(data_b), tbl[i].e1);
      if (tbl[i].e2 >= 0) chk($sformatf("row%0d noflag err_empty", i), int'(empty_c), tbl[i].e2);
    end

    // Repeated underflow drives err_count into saturation.
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 1, 8'h00, 1, 0);
    repeat (300) @(posedge clk);
    #1;
    chk_main("saturate", 0, 5'b01000, 255, 2);

    // A clear with no event returns everything to zero.
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1, 1);
    @(posedge clk);
    #1;
    chk_main("clear", 0, 5'b00000, 0, 0);

    @(negedge clk);
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
